// File: rtl/up5k_zx_spram.sv
// up5k_zx_spram -- CPU byte port plus loader word stream onto 1..4 iCE40UP5K
// single-port RAM banks, each 16K x 16. The banks are modelled behaviourally
// here (nibble-masked write, registered read data); on silicon each g_bank
// instance maps to one SB_SPRAM256KA with STANDBY=0, SLEEP=0, POWEROFF=1.
//
// Byte address A: bank A[AW-1:15], word A[14:1], lane A[0].
// Bytes below RO_TOP are write-protected for the CPU; the loader ignores it.
// Bank indices >= BANKS read as 8'hFF and swallow writes.
//
// Optional feature: define UP5K_SPRAM_LOAD_SUM_EN to add the ld_sum output,
// a running modulo-2^16 sum of every accepted loader word.
module up5k_zx_spram #(
  parameter int BANKS  = 1,
  parameter int AW     = 15 + $clog2(BANKS),
  parameter int RO_TOP = 16384
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ack,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-2:0] ld_addr,
  input  logic [15:0]   ld_data,
  output logic [15:0]   ld_count
`ifdef UP5K_SPRAM_LOAD_SUM_EN
  ,
  output logic [15:0]   ld_sum
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BANKS_L = 4'(BANKS);

  state_t state;
  state_t state_nxt;

  // Address-decode helpers; zero-extension keeps the bank slice legal even
  // when AW is exactly 15 (single bank, bank field is empty).
  function automatic logic [2:0] bank_of_byte(input logic [AW-1:0] a);
    logic [AW+2:0] e;
    e = {3'b000, a};
    return e[17:15];
  endfunction

  function automatic logic [2:0] bank_of_word(input logic [AW-2:0] w);
    logic [AW+2:0] e;
    e = {3'b000, w, 1'b0};
    return e[17:15];
  endfunction

  function automatic logic bank_ok(input logic [2:0] b);
    return ({1'b0, b} < BANKS_L);
  endfunction

  function automatic logic is_ro(input logic [AW-1:0] a);
    return (32'(a) < 32'(RO_TOP));
  endfunction

  function automatic logic [7:0] lane_sel(input logic [15:0] w, input logic lane,
                                          input logic oor);
    if (oor)  return 8'hFF;
    if (lane) return w[15:8];
    return w[7:0];
  endfunction

  // Stage p0: request decode and RAM port drive
  logic        acc_p0;
  logic        ld_fire_p0;
  logic        mem_en_p0;
  logic        mem_wren_p0;
  logic [2:0]  mem_bank_p0;
  logic [13:0] mem_word_p0;
  logic [15:0] mem_din_p0;
  logic [3:0]  mem_mask_p0;
  logic [2:0]  cpu_bank_p0;
  logic [2:0]  ld_bank_p0;

  logic [15:0] bank_dout [BANKS];

  // Stage p1: read context held through RD_WAIT
  logic [2:0]  rd_bank_p1;
  logic        rd_lane_p1;
  logic        rd_oor_p1;
  logic [15:0] rd_word_p1;
  logic [7:0]  rd_byte_p1;

  // State register; reset forces IDLE, which also aborts an in-flight read.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: only a CPU read leaves IDLE; the read path is a fixed walk.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = (cpu_req && !cpu_we) ? RD_WAIT : IDLE;
      RD_WAIT: state_nxt = RD_DONE;
      RD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Port arbitration and RAM control; CPU wins over the loader in IDLE.
  always_comb begin
    cpu_bank_p0 = bank_of_byte(cpu_addr);
    ld_bank_p0  = bank_of_word(ld_addr);
    ld_ready    = (state == IDLE) && !cpu_req && resetn;
    acc_p0      = (state == IDLE) && cpu_req && resetn;
    ld_fire_p0  = ld_valid && ld_ready;
    mem_en_p0   = 1'b0;
    mem_wren_p0 = 1'b0;
    mem_bank_p0 = 3'd0;
    mem_word_p0 = 14'd0;
    mem_din_p0  = 16'd0;
    mem_mask_p0 = 4'b0000;
    if (acc_p0) begin
      mem_en_p0   = bank_ok(cpu_bank_p0);
      mem_wren_p0 = cpu_we && !is_ro(cpu_addr);
      mem_bank_p0 = cpu_bank_p0;
      mem_word_p0 = cpu_addr[14:1];
      mem_din_p0  = {cpu_wdata, cpu_wdata};
      mem_mask_p0 = cpu_addr[0] ? 4'b1100 : 4'b0011;
    end else if (ld_fire_p0) begin
      mem_en_p0   = bank_ok(ld_bank_p0);
      mem_wren_p0 = 1'b1;
      mem_bank_p0 = ld_bank_p0;
      mem_word_p0 = ld_addr[13:0];
      mem_din_p0  = ld_data;
      mem_mask_p0 = 4'b1111;
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic        cs;
    logic [15:0] mem [16384];
    logic [15:0] dout_q;

    assign cs           = mem_en_p0 && (mem_bank_p0 == 3'(b));
    assign bank_dout[b] = dout_q;

    // One SPRAM bank: nibble-masked write, otherwise registered read.
    always_ff @(posedge clk) begin
      if (cs) begin
        if (mem_wren_p0) begin
          if (mem_mask_p0[0]) mem[mem_word_p0][3:0]   <= mem_din_p0[3:0];
          if (mem_mask_p0[1]) mem[mem_word_p0][7:4]   <= mem_din_p0[7:4];
          if (mem_mask_p0[2]) mem[mem_word_p0][11:8]  <= mem_din_p0[11:8];
          if (mem_mask_p0[3]) mem[mem_word_p0][15:12] <= mem_din_p0[15:12];
        end else begin
          dout_q <= mem[mem_word_p0];
        end
      end
    end
  end

  // Latch bank/lane of an accepted read for the byte mux one cycle later.
  always_ff @(posedge clk) begin
    if (acc_p0 && !cpu_we) begin
      rd_bank_p1 <= cpu_bank_p0;
      rd_lane_p1 <= cpu_addr[0];
      rd_oor_p1  <= !bank_ok(cpu_bank_p0);
    end
  end

  // Bank mux of the registered RAM output.
  always_comb begin
    rd_word_p1 = 16'hFFFF;
    for (int b = 0; b < BANKS; b++) begin
      if (rd_bank_p1 == 3'(b)) rd_word_p1 = bank_dout[b];
    end
    rd_byte_p1 = lane_sel(rd_word_p1, rd_lane_p1, rd_oor_p1);
  end

  // Stage p2: registered CPU response and loader counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= 8'h00;
      ld_count  <= 16'd0;
    end else begin
      cpu_ack <= (acc_p0 && cpu_we) || (state == RD_WAIT);
      if (state == RD_WAIT) cpu_rdata <= rd_byte_p1;
      if (ld_fire_p0)       ld_count  <= ld_count + 16'd1;
    end
  end

`ifdef UP5K_SPRAM_LOAD_SUM_EN
  // Running checksum of accepted loader words, visible the cycle after.
  always_ff @(posedge clk) begin
    if (!resetn)         ld_sum <= 16'd0;
    else if (ld_fire_p0) ld_sum <= ld_sum + ld_data;
  end
`endif

endmodule

// File: tb/tb_up5k_zx_spram.sv
// Bench for up5k_zx_spram with three banks (bank index 3 is out of range).
// Directed vector table, hand sequences for arbitration and reset, then a
// random phase against a byte-array reference model.
module tb_up5k_zx_spram;

  localparam int BANKS  = 3;
  localparam int AW     = 17;
  localparam int RO_TOP = 16384;
  localparam int MEMB   = BANKS * 32768;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic          cpu_ack;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-2:0] ld_addr;
  logic [15:0]   ld_data;
  logic [15:0]   ld_count;
`ifdef UP5K_SPRAM_LOAD_SUM_EN
  logic [15:0]   ld_sum;
`endif

  up5k_zx_spram #(.BANKS(BANKS), .AW(AW), .RO_TOP(RO_TOP)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_count(ld_count)
`ifdef UP5K_SPRAM_LOAD_SUM_EN
    , .ld_sum(ld_sum)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: flat byte array, loader/CPU rules applied directly.
  logic [7:0]  mdl [0:131071];
  logic [15:0] m_count = 16'd0;
  logic [15:0] m_sum   = 16'd0;

  function automatic logic [7:0] m_read(input int a);
    return (a >= MEMB) ? 8'hFF : mdl[a];
  endfunction

  task automatic m_write(input int a, input logic [7:0] d);
    if (a >= RO_TOP && a < MEMB) mdl[a] = d;
  endtask

  task automatic m_load(input int w, input logic [15:0] d);
    if (2 * w < MEMB) begin
      mdl[2 * w]     = d[7:0];
      mdl[2 * w + 1] = d[15:8];
    end
    m_count = m_count + 16'd1;
    m_sum   = m_sum + d;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one CPU access from IDLE; returns read byte and ack latency.
  task automatic do_cpu(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int lat);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
    lat = 1;
    while (!cpu_ack && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = cpu_rdata;
    if (!we) @(posedge clk);
  endtask

  task automatic do_load(input logic [AW-2:0] w, input logic [15:0] d);
    int budget;
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = w; ld_data = d;
    budget = 0;
    #1;
    while (!ld_ready && budget < 16) begin
      @(negedge clk); #1;
      budget++;
    end
    check("ld_ready_wait", 32'(budget < 16), 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    m_load(int'(w), d);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    exp;
  } vec_t;

  vec_t vecs [19];

  initial begin
    logic [7:0] rd;
    int lat;
    int a;
    int kind;
    logic [7:0] d8;
    int bases [4];

    vecs[0]  = '{1'b0, 17'h00000, 8'h00, 8'hAA};
    vecs[1]  = '{1'b0, 17'h00001, 8'h00, 8'hBB};
    vecs[2]  = '{1'b0, 17'h00002, 8'h00, 8'hCC};
    vecs[3]  = '{1'b0, 17'h00003, 8'h00, 8'hDD};
    vecs[4]  = '{1'b0, 17'h08001, 8'h00, 8'h77};
    vecs[5]  = '{1'b1, 17'h08001, 8'h5A, 8'h00};
    vecs[6]  = '{1'b0, 17'h08001, 8'h00, 8'h5A};
    vecs[7]  = '{1'b0, 17'h08000, 8'h00, 8'h66};
    vecs[8]  = '{1'b1, 17'h00000, 8'h11, 8'h00};
    vecs[9]  = '{1'b0, 17'h00000, 8'h00, 8'hAA};
    vecs[10] = '{1'b0, 17'h18000, 8'h00, 8'hFF};
    vecs[11] = '{1'b1, 17'h18000, 8'h99, 8'h00};
    vecs[12] = '{1'b0, 17'h18000, 8'h00, 8'hFF};
    vecs[13] = '{1'b0, 17'h10000, 8'h00, 8'h33};
    vecs[14] = '{1'b1, 17'h03FFF, 8'hEE, 8'h00};
    vecs[15] = '{1'b0, 17'h03FFF, 8'h00, 8'h22};
    vecs[16] = '{1'b1, 17'h04000, 8'hEE, 8'h00};
    vecs[17] = '{1'b0, 17'h04000, 8'h00, 8'hEE};
    vecs[18] = '{1'b0, 17'h04001, 8'h00, 8'h88};

    resetn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_valid = 1'b1; ld_addr = 16'h0030; ld_data = 16'hDEAD;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(cpu_ack), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'h00);
    check("rst_count", 32'(ld_count), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
`ifdef UP5K_SPRAM_LOAD_SUM_EN
    check("rst_sum", 32'(ld_sum), 32'd0);
`endif
    ld_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    do_load(16'h0000, 16'hBBAA);
    do_load(16'h0001, 16'hDDCC);
    check("count_two", 32'(ld_count), 32'd2);
    do_load(16'h4000, 16'h7766);
    do_load(16'h8000, 16'h4433);
    do_load(16'h1FFF, 16'h2211);
    do_load(16'h2000, 16'h8877);
    do_load(16'hC000, 16'h1357);
    check("count_seven", 32'(ld_count), 32'd7);

    for (int i = 0; i < 19; i++) begin
      do_cpu(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      if (vecs[i].we) begin
        m_write(int'(vecs[i].addr), vecs[i].wdata);
        check($sformatf("vec%0d_wr_lat", i), 32'(lat), 32'd1);
      end else begin
        check($sformatf("vec%0d_rd_lat", i), 32'(lat), 32'd2);
        check($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].exp));
      end
    end

    // Out-of-range write must not alias into bank 0 or bank 2.
    do_cpu(1'b0, 17'h00000, 8'h00, rd, lat);
    check("oor_alias_b0", 32'(rd), 32'hAA);
    do_cpu(1'b0, 17'h10000, 8'h00, rd, lat);
    check("oor_alias_b2", 32'(rd), 32'h33);

    // Simultaneous CPU read and loader word: CPU first, load after.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00001;
    ld_valid = 1'b1; ld_addr = 16'h0002; ld_data = 16'h1234;
    #1;
    check("prio_ready_n", 32'(ld_ready), 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    check("prio_ready_wait", 32'(ld_ready), 32'd0);
    check("prio_count_wait", 32'(ld_count), 32'(m_count));
    @(posedge clk); #1;
    check("prio_ack", 32'(cpu_ack), 32'd1);
    check("prio_rdata", 32'(cpu_rdata), 32'hBB);
    check("prio_ready_done", 32'(ld_ready), 32'd0);
    @(posedge clk); #1;
    check("prio_ack_pulse", 32'(cpu_ack), 32'd0);
    check("prio_ready_idle", 32'(ld_ready), 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    m_load(2, 16'h1234);
    check("prio_count", 32'(ld_count), 32'(m_count));
    do_cpu(1'b0, 17'h00004, 8'h00, rd, lat);
    check("prio_lo", 32'(rd), 32'h34);
    do_cpu(1'b0, 17'h00005, 8'h00, rd, lat);
    check("prio_hi", 32'(rd), 32'h12);

    // Random phase over four 32-byte windows, one per bank index.
    bases[0] = 0; bases[1] = 32'h8000; bases[2] = 32'h10000; bases[3] = 32'h18000;
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 16; w++)
        do_load(AW'(bases[b] + 2 * w) >> 1, 16'($urandom));
    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 2));
      a = bases[$urandom_range(0, 3)] + int'($urandom_range(0, 31));
      d8 = 8'($urandom);
      if (kind == 0) begin
        do_load(AW'(a) >> 1, 16'($urandom));
      end else if (kind == 1) begin
        do_cpu(1'b0, AW'(a), 8'h00, rd, lat);
        check($sformatf("rnd%0d_rd_lat", n), 32'(lat), 32'd2);
        check($sformatf("rnd%0d_rd_%0h", n, a), 32'(rd), 32'(m_read(a)));
      end else begin
        do_cpu(1'b1, AW'(a), d8, rd, lat);
        m_write(a, d8);
        check($sformatf("rnd%0d_wr_lat", n), 32'(lat), 32'd1);
      end
    end
    check("rnd_count", 32'(ld_count), 32'(m_count));
`ifdef UP5K_SPRAM_LOAD_SUM_EN
    check("rnd_sum", 32'(ld_sum), 32'(m_sum));
`endif

    // Reset in RD_WAIT aborts the read; contents survive.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00002;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("abort_ack", 32'(cpu_ack), 32'd0);
    check("abort_count", 32'(ld_count), 32'd0);
    check("abort_rdata", 32'(cpu_rdata), 32'h00);
    check("abort_ready", 32'(ld_ready), 32'd0);
    m_count = 16'd0;
    m_sum   = 16'd0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("abort_no_late_ack0", 32'(cpu_ack), 32'd0);
    @(posedge clk); #1;
    check("abort_no_late_ack1", 32'(cpu_ack), 32'd0);
    do_cpu(1'b0, 17'h00002, 8'h00, rd, lat);
    check("abort_reread", 32'(rd), 32'(m_read(2)));

    do_load(16'h0020, 16'hFFFF);
    do_load(16'h0021, 16'h0002);
    check("sum_count", 32'(ld_count), 32'd2);
`ifdef UP5K_SPRAM_LOAD_SUM_EN
    check("sum_wrap", 32'(ld_sum), 32'h0001);
`endif
    do_cpu(1'b0, 17'h00042, 8'h00, rd, lat);
    check("sum_word_lo", 32'(rd), 32'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
